// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package instruction_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] iword;
        logic [XLEN-1:0] pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Parameterised synchronous shift FIFO; entry 0 is always the head so the
// head payload and its valid bit come straight from flops.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               wr_idx;
    logic                        pop_eff;

    assign pop_eff    = pop && vld_q[0];
    assign head       = mem_q[0];
    assign head_valid = vld_q[0];
    assign count      = cnt_q;

    // Shift on pop, then write the new entry just behind the last valid one.
    always_comb begin
        mem_d  = mem_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop_eff);
        wr_idx = cnt_q - CW'(pop_eff);
        if (pop_eff) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                mem_d[i] = mem_q[i+1];
                vld_d[i] = vld_q[i+1];
            end
            vld_d[DEPTH-1] = 1'b0;
        end
        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    mem_d[i] = wdata;
                    vld_d[i] = 1'b1;
                end
            end
        end
        if (clear) begin
            vld_d = '0;
            cnt_d = '0;
        end
    end

    // Storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// buffering, redirect flush and misaligned-target halt.
// Optional build macro IFETCH_PERF_EN adds the perf_fetch_count output.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_iword,
    output logic [XLEN-1:0] out_pc,
    output logic            misalign
`ifdef IFETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_count
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            req_valid_q, req_valid_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            misalign_q, misalign_d;

    logic            req_acc, rsp_live, out_pop, buf_push;
    logic [SW-1:0]   occ_next, credit_used;
    ibuf_entry_t     buf_wdata, buf_head;
    logic            buf_head_valid;
    logic [CW-1:0]   buf_count;
    logic [XLEN-1:0] pcq_head;
    logic            pcq_head_valid;
    logic [CW-1:0]   unused_pcq_count;

    assign req_acc   = req_valid_q && imem_req_ready;
    assign rsp_live  = imem_rsp_valid && (outstanding_q != '0);
    assign out_pop   = buf_head_valid && out_ready;
    assign buf_push  = rsp_live && (state_q == ST_RUN) && !redirect_valid && pcq_head_valid;
    assign buf_wdata = '{iword: imem_rsp_data, pc: pcq_head};

    // Instruction buffer holding {iword, pc} for decode.
    ifetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(ibuf_entry_t))
    ) u_ibuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect_valid),
        .push       (buf_push),
        .wdata      (buf_wdata),
        .pop        (out_pop),
        .head       (buf_head),
        .head_valid (buf_head_valid),
        .count      (buf_count)
    );

    // Addresses of accepted requests, matched to responses in order.
    ifetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN)
    ) u_pcq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect_valid),
        .push       (req_acc),
        .wdata      (fetch_pc_q),
        .pop        (buf_push),
        .head       (pcq_head),
        .head_valid (pcq_head_valid),
        .count      (unused_pcq_count)
    );

    // Next-state, fetch PC, credit and redirect handling.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = req_acc ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_acc) - CW'(rsp_live);
        discard_d     = discard_q;
        misalign_d    = misalign_q;
        occ_next      = SW'(buf_count) + SW'(buf_push) - SW'(out_pop);

        case (state_q)
            ST_FLUSH: begin
                if (discard_q == '0) begin
                    state_d = ST_RUN;
                end else if (rsp_live) begin
                    discard_d = discard_q - CW'(1);
                end
            end
            ST_HALT: begin
                if (rsp_live && (discard_q != '0)) begin
                    discard_d = discard_q - CW'(1);
                end
            end
            default: ;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            misalign_d = (redirect_pc[1:0] != 2'b00);
            discard_d  = outstanding_d;
            occ_next   = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = ST_HALT;
            end else if (outstanding_d == '0) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_FLUSH;
            end
        end

        credit_used = SW'(outstanding_d) + occ_next;
        req_valid_d = (state_d == ST_RUN) && (credit_used < SW'(BUF_DEPTH));
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            req_valid_q   <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_valid_q   <= req_valid_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = buf_head_valid;
    assign out_iword      = buf_head.iword;
    assign out_pc         = buf_head.pc;
    assign misalign       = misalign_q;

`ifdef IFETCH_PERF_EN
    logic [XLEN-1:0] perf_q, perf_d;

    // Count instructions handed to decode.
    always_comb begin
        perf_d = perf_q;
        if (out_pop) begin
            perf_d = perf_q + XLEN'(1);
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_fetch_count = perf_q;
`else
    // Performance counter not built.
`endif

endmodule
